result_drain: RTL and testbench



---
 rtl/result_drain.sv | 95 +++++++++
 tb/tb_result_drain.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: streams rows of a results SRAM out as one signed lane per ready/valid beat.
module result_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDRESSSIZE-1:0]                 row_count,
  output logic                                   sram_rd_en,
  output logic [ADDRESSSIZE-1:0]                 sram_rd_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_rd_data,
  output logic [PARTIAL_SUM_BW-1:0]              out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_row_end,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);
  localparam int LW = MATRIX_SIZE > 1 ? $clog2(MATRIX_SIZE) : 1;
  typedef enum logic [2:0] {IDLE, RD, LD, SEND, DONE} state_t;
  state_t                              state;
  logic [ADDRESSSIZE-1:0]              row, count;
  logic [LW-1:0]                       lane;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] lanes;
  logic [ADDRESSSIZE:0]                row_next;
  logic                                lane_last;
  // one extra bit so row+1 never wraps when row_count is at its maximum
  assign row_next    = {1'b0, row} + 1'b1;
  assign lane_last   = lane == LW'(MATRIX_SIZE - 1);
  assign out_data    = out_valid ? lanes[lane*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] : '0;
  assign out_row_end = out_valid && lane_last;
  assign out_last    = out_row_end && row == count - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      count           <= '0;
      lane            <= '0;
      lanes           <= '0;
      sram_rd_en      <= 1'b0;
      sram_rd_address <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      sram_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count <= row_count;
          row   <= '0;
          busy  <= 1'b1;
          if (row_count != '0) begin
            state           <= RD;
            sram_rd_en      <= 1'b1;
            sram_rd_address <= '0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        RD: state <= LD;
        LD: begin
          lanes     <= sram_rd_data;
          lane      <= '0;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (out_ready) begin
          lane <= lane + 1'b1;
          if (lane_last) begin
            out_valid <= 1'b0;
            if (row_next < {1'b0, count}) begin
              row             <= row_next[ADDRESSSIZE-1:0];
              sram_rd_en      <= 1'b1;
              sram_rd_address <= row_next[ADDRESSSIZE-1:0];
              state           <= RD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: random and directed drains checked against a queue-based model of the beat stream.
module tb_result_drain;
  localparam int A = 10, PSW = 24, M = 32;
  typedef struct {logic [PSW-1:0] data; logic row_end; logic last;} beat_t;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [A-1:0] row_count = '0;
  logic sram_rd_en, out_valid, out_row_end, out_last, busy, done;
  logic [A-1:0] sram_rd_address;
  logic [PSW*M-1:0] sram_rd_data = '0;
  logic [PSW-1:0] out_data;
  logic [PSW-1:0] mem [0:7][0:M-1];
  beat_t exp_q[$];
  int addr_q[$];
  logic [PSW-1:0] got_q[$];
  int tests = 0, fails = 0, first_rd, first_v, d;
  bit mon = 0, stall_prev = 0, found;
  logic [PSW+1:0] prev_word;

  result_drain #(.ADDRESSSIZE(A), .PARTIAL_SUM_BW(PSW), .MATRIX_SIZE(M)) dut (
    .clk(clk), .rst(rst), .start(start), .row_count(row_count),
    .sram_rd_en(sram_rd_en), .sram_rd_address(sram_rd_address), .sram_rd_data(sram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_end(out_row_end), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_rd_en)
      for (int k = 0; k < M; k++) sram_rd_data[k*PSW +: PSW] <= mem[sram_rd_address[2:0]][k];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic load(input int n);
    exp_q.delete();
    addr_q.delete();
    got_q.delete();
    for (int r = 0; r < n; r++) begin
      addr_q.push_back(r);
      for (int k = 0; k < M; k++) exp_q.push_back('{mem[r][k], k == M-1, k == M-1 && r == n-1});
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) for (int k = 0; k < M; k++) mem[r][k] = PSW'($urandom);
  endtask

  always @(negedge clk) if (mon) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        chk("beat_data", out_data, exp_q[0].data);
        chk("beat_row_end", out_row_end, exp_q[0].row_end);
        chk("beat_last", out_last, exp_q[0].last);
      end
      if (stall_prev) chk("stall_hold", {out_data, out_row_end, out_last}, prev_word);
      if (out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got_q.push_back(out_data);
      end
    end else chk("idle_outputs", {out_data, out_row_end, out_last}, 0);
    if (sram_rd_en) begin
      if (addr_q.size() == 0) chk("extra_read", 1, 0);
      else chk("rd_addr", sram_rd_address, addr_q.pop_front());
    end
    stall_prev = out_valid && !out_ready;
    prev_word = {out_data, out_row_end, out_last};
  end

  task automatic run(input int n, input bit rnd, input bit poke, output int done_c);
    load(n);
    @(posedge clk); #1;
    start = 1;
    row_count = A'(n);
    done_c = -1; first_rd = -1; first_v = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      chk("busy", busy, c != 0);
      if (sram_rd_en && first_rd < 0) first_rd = c;
      if (out_valid && first_v < 0) first_v = c;
      if (done) begin done_c = c; break; end
      @(posedge clk); #1;
      start = poke && c == 5;
      row_count = A'($urandom);
      out_ready = rnd ? 1'($urandom) : 1'b1;
    end
    if (done_c < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    start = 0;
    out_ready = 1;
    @(negedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_pulse_width", done, 0);
    chk("beats_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
  endtask

  initial begin
    fill_rand();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {out_row_end, out_last, sram_rd_en}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", sram_rd_address, 0);
    mon = 1;
    // single row, lane k = k+1
    for (int k = 0; k < M; k++) mem[0][k] = PSW'(k + 1);
    run(1, 0, 0, d);
    chk("single_done_cycle", d, 35);
    chk("single_first_rd", first_rd, 1);
    chk("single_first_valid", first_v, 3);
    chk("single_beat1", got_q[0], 1);
    chk("single_beat32", got_q[31], 32);
    // three rows, lane k of row r = 100r+k, with a start poked mid-drain
    for (int r = 0; r < 3; r++) for (int k = 0; k < M; k++) mem[r][k] = PSW'(100*r + k);
    run(3, 0, 1, d);
    chk("multi_done_cycle", d, 103);
    chk("multi_beat_count", got_q.size(), 96);
    chk("multi_last_value", got_q[95], 231);
    // signed lanes
    fill_rand();
    mem[0][0] = 24'hFFFFFF;
    mem[0][1] = 24'h800000;
    run(1, 0, 0, d);
    chk("signed_minus1", 64'(signed'(got_q[0])), 64'(-1));
    chk("signed_min", 64'(signed'(got_q[1])), 64'(-8388608));
    // zero rows
    run(0, 0, 0, d);
    chk("zero_done_cycle", d, 1);
    chk("zero_no_read", first_rd, -1);
    chk("zero_no_valid", first_v, -1);
    // backpressure
    fill_rand();
    run(2, 1, 0, d);
    chk("bp_beat_count", got_q.size(), 64);
    // reset at lane 10 of row 1, with start asserted alongside
    fill_rand();
    load(2);
    @(posedge clk); #1;
    start = 1;
    row_count = 2;
    @(posedge clk); #1;
    start = 0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk); #1;
      found = out_valid && exp_q.size() == M - 11;
    end
    if (!found) chk("rst_point_timeout", 0, 1);
    rst = 1;
    start = 1;
    @(posedge clk); #1;
    rst = 0;
    start = 0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", {out_valid, out_row_end, out_last, sram_rd_en, done}, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_addr", sram_rd_address, 0);
    run(2, 0, 0, d);
    chk("post_rst_done_cycle", d, 69);
    // random drains
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      run(int'($urandom_range(1, 4)), 1, t[0], d);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
